// File: rtl/bullet_pool.sv
// Player shot pool: turns fire-button edges into bullets at the ship's nose,
// moves them upward once per frame and retires them on leaving the field or on a hit.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int BULLET_W    = 2,
  parameter int BULLET_H    = 6,
  parameter int SPEED       = 4,
  parameter int COOLDOWN    = 8,
  parameter int Y_TOP       = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       move,
  input  logic       shoot,
  input  logic [9:0] ship_x,
  input  logic [9:0] ship_y,
  input  logic       hit_target,
  output logic       draw_bullet,
  output logic       bullet_hit,
  output logic [2:0] hit_count,
  output logic [2:0] active_count
);

  localparam int          CW         = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [10:0] RETIRE_LIM = 11'(Y_TOP + SPEED);
  localparam logic [9:0]  SPEED_V    = 10'(SPEED);
  localparam logic [9:0]  HEIGHT_V   = 10'(BULLET_H);
  localparam logic [10:0] W_EXT      = 11'(BULLET_W);
  localparam logic [10:0] H_EXT      = 11'(BULLET_H);

  function automatic logic [3:0] popcnt(input logic [NUM_BULLETS-1:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      s = s + 4'(v[i]);
    end
    return s;
  endfunction

  function automatic logic [2:0] sat3(input logic [3:0] v);
    return (v > 4'd7) ? 3'd7 : v[2:0];
  endfunction

  logic                   r_shoot_meta, r_shoot_sync, r_shoot_prev, r_fire_pending;
  logic [NUM_BULLETS-1:0] r_active, r_hit;
  logic [9:0]             r_x [NUM_BULLETS];
  logic [9:0]             r_y [NUM_BULLETS];
  logic [CW-1:0]          r_cooldown;
  logic                   r_bullet_hit;
  logic [2:0]             r_hit_count, r_active_count;

  logic [NUM_BULLETS-1:0] w_slot_draw, w_retire_hit, w_survive;
  logic                   w_fire_edge, w_found, w_spawn;
  logic [2:0]             w_spawn_idx;
  logic [3:0]             w_hit_sum, w_live_sum;

  assign w_fire_edge = r_shoot_sync & ~r_shoot_prev;

  // Per-slot pixel coverage; 11-bit sums keep the right/bottom bounds from wrapping.
  always_comb begin
    w_slot_draw = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      w_slot_draw[i] = r_active[i]
        && ({1'b0, hcount} >= {1'b0, r_x[i]}) && ({1'b0, hcount} < ({1'b0, r_x[i]} + W_EXT))
        && ({1'b0, vcount} >= {1'b0, r_y[i]}) && ({1'b0, vcount} < ({1'b0, r_y[i]} + H_EXT));
    end
  end

  assign draw_bullet = |w_slot_draw;

  // Frame-update decisions: hit retirement, off-screen retirement, spawn slot choice.
  always_comb begin
    w_retire_hit = '0;
    w_survive    = '0;
    w_found      = 1'b0;
    w_spawn_idx  = 3'd0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      w_retire_hit[i] = r_active[i] & r_hit[i];
      w_survive[i]    = r_active[i] & ~r_hit[i] & ({1'b0, r_y[i]} >= RETIRE_LIM);
      if (!w_survive[i] && !w_found) begin
        w_found     = 1'b1;
        w_spawn_idx = 3'(i);
      end else begin
        w_found     = w_found;
        w_spawn_idx = w_spawn_idx;
      end
    end
    w_hit_sum  = popcnt(w_retire_hit);
    w_live_sum = popcnt(r_active);
    w_spawn    = r_fire_pending && (r_cooldown == '0) && (ship_y >= HEIGHT_V) && w_found;
  end

  // Fire button synchroniser and edge latch; an edge coinciding with move survives the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shoot_meta   <= 1'b0;
      r_shoot_sync   <= 1'b0;
      r_shoot_prev   <= 1'b0;
      r_fire_pending <= 1'b0;
    end else begin
      r_shoot_meta <= shoot;
      r_shoot_sync <= r_shoot_meta;
      r_shoot_prev <= r_shoot_sync;
      if (w_fire_edge) begin
        r_fire_pending <= 1'b1;
      end else if (move) begin
        r_fire_pending <= 1'b0;
      end else begin
        r_fire_pending <= r_fire_pending;
      end
    end
  end

  // Slot state, cooldown and hit reporting; hit flags collect between moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active     <= '0;
      r_hit        <= '0;
      r_cooldown   <= '0;
      r_bullet_hit <= 1'b0;
      r_hit_count  <= 3'd0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        r_x[i] <= 10'd0;
        r_y[i] <= 10'd0;
      end
    end else if (move) begin
      r_hit        <= '0;
      r_hit_count  <= sat3(w_hit_sum);
      r_bullet_hit <= (w_hit_sum != 4'd0);
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (w_spawn && (w_spawn_idx == 3'(i))) begin
          r_active[i] <= 1'b1;
          r_x[i]      <= ship_x + 10'd7;
          r_y[i]      <= ship_y - HEIGHT_V;
        end else if (w_survive[i]) begin
          r_active[i] <= 1'b1;
          r_y[i]      <= r_y[i] - SPEED_V;
        end else begin
          r_active[i] <= 1'b0;
        end
      end
      if (w_spawn) begin
        r_cooldown <= CW'(COOLDOWN);
      end else if (r_cooldown != '0) begin
        r_cooldown <= r_cooldown - CW'(1);
      end else begin
        r_cooldown <= r_cooldown;
      end
    end else begin
      r_bullet_hit <= 1'b0;
      if (pixpulse && hit_target) begin
        r_hit <= r_hit | w_slot_draw;
      end else begin
        r_hit <= r_hit;
      end
    end
  end

  // Live-bullet count trails the slot registers by one clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active_count <= 3'd0;
    end else begin
      r_active_count <= sat3(w_live_sum);
    end
  end

  assign bullet_hit   = r_bullet_hit;
  assign hit_count    = r_hit_count;
  assign active_count = r_active_count;

endmodule

// File: tb/tb_bullet_pool.sv
// Randomised self-checking bench for bullet_pool against a slot-list reference model.
module tb_bullet_pool;

  localparam int NB = 4;
  localparam int BW = 2;
  localparam int BH = 6;
  localparam int SP = 4;
  localparam int CD = 8;
  localparam int YT = 0;

  logic       clk, rst, pixpulse, move, shoot, hit_target;
  logic [9:0] hcount, vcount, ship_x, ship_y;
  logic       draw_bullet, bullet_hit;
  logic [2:0] hit_count, active_count;

  int checks   = 0;
  int failures = 0;

  int m_act [NB];
  int m_x   [NB];
  int m_y   [NB];
  int m_hit [NB];
  int m_pend, m_cd, exp_hc, exp_bh;

  bullet_pool dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .move(move), .shoot(shoot), .ship_x(ship_x), .ship_y(ship_y), .hit_target(hit_target),
    .draw_bullet(draw_bullet), .bullet_hit(bullet_hit), .hit_count(hit_count),
    .active_count(active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_draw(int hc, int vc);
    int d;
    d = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_act[i] != 0 && hc >= m_x[i] && hc < m_x[i] + BW && vc >= m_y[i] && vc < m_y[i] + BH) d = 1;
    end
    return d;
  endfunction

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < NB; i++) c += m_act[i];
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) begin
      m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_hit[i] = 0;
    end
    m_pend = 0; m_cd = 0; exp_hc = 0; exp_bh = 0;
  endtask

  task automatic model_move();
    int n, cd_before, slot;
    n = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_act[i] != 0 && m_hit[i] != 0) begin
        m_act[i] = 0;
        n++;
      end
    end
    exp_hc = (n > 7) ? 7 : n;
    exp_bh = (n != 0) ? 1 : 0;
    for (int i = 0; i < NB; i++) begin
      if (m_act[i] != 0) begin
        if (m_y[i] < YT + SP) m_act[i] = 0;
        else m_y[i] = m_y[i] - SP;
      end
    end
    cd_before = m_cd;
    if (m_cd != 0) m_cd--;
    slot = -1;
    for (int i = NB - 1; i >= 0; i--) if (m_act[i] == 0) slot = i;
    if (m_pend != 0 && cd_before == 0 && int'(ship_y) >= BH && slot >= 0) begin
      m_act[slot] = 1;
      m_x[slot]   = (int'(ship_x) + 7) % 1024;
      m_y[slot]   = int'(ship_y) - BH;
      m_cd        = CD;
    end
    for (int i = 0; i < NB; i++) m_hit[i] = 0;
    m_pend = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; shoot = 1'b0; move = 1'b0; pixpulse = 1'b0; hit_target = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic press_shoot();
    shoot = 1'b1;
    repeat (4) @(negedge clk);
    m_pend = 1;
    shoot = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_move(string name);
    move = 1'b1;
    model_move();
    @(negedge clk);
    move = 1'b0;
    checks++;
    if (bullet_hit !== 1'(exp_bh)) begin
      failures++;
      $display("FAIL %s bullet_hit got=%0b exp=%0d", name, bullet_hit, exp_bh);
    end
    checks++;
    if (hit_count !== 3'(exp_hc)) begin
      failures++;
      $display("FAIL %s hit_count got=%0d exp=%0d", name, hit_count, exp_hc);
    end
    @(negedge clk);
    checks++;
    if (bullet_hit !== 1'b0) begin
      failures++;
      $display("FAIL %s bullet_hit_pulse_width got=%0b exp=0", name, bullet_hit);
    end
    checks++;
    if (active_count !== 3'(model_count())) begin
      failures++;
      $display("FAIL %s active_count got=%0d exp=%0d", name, active_count, model_count());
    end
  endtask

  // Presents one pixel with pixpulse; expected draw comes from the model.
  task automatic probe(int hc, int vc, int ht, string name);
    hcount = 10'(hc); vcount = 10'(vc); hit_target = 1'(ht); pixpulse = 1'b1;
    #1;
    checks++;
    if (draw_bullet !== 1'(model_draw(hc, vc))) begin
      failures++;
      $display("FAIL %s draw(%0d,%0d) got=%0b exp=%0d", name, hc, vc, draw_bullet, model_draw(hc, vc));
    end
    if (ht != 0) begin
      for (int i = 0; i < NB; i++) begin
        if (m_act[i] != 0 && hc >= m_x[i] && hc < m_x[i] + BW && vc >= m_y[i] && vc < m_y[i] + BH) m_hit[i] = 1;
      end
    end
    @(negedge clk);
    pixpulse = 1'b0; hit_target = 1'b0;
    @(negedge clk);
  endtask

  task automatic probe_exp(int hc, int vc, logic exp, string name);
    hcount = 10'(hc); vcount = 10'(vc);
    #1;
    checks++;
    if (draw_bullet !== exp) begin
      failures++;
      $display("FAIL %s draw(%0d,%0d) got=%0b exp=%0b", name, hc, vc, draw_bullet, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    ship_x = 10'd200; ship_y = 10'd400;
    press_shoot();
    do_move("reset_setup");
    shoot = 1'b1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    hcount = 10'd207; vcount = 10'd394;
    #1;
    checks++;
    if ({draw_bullet, bullet_hit, hit_count, active_count} !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%0b/%0b/%0d/%0d exp=0/0/0/0", draw_bullet, bullet_hit, hit_count, active_count);
    end
    shoot = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    do_move("reset_no_spawn");
    probe_exp(207, 394, 1'b0, "reset_discard");
  endtask

  task automatic test_single_shot();
    do_reset();
    ship_x = 10'd200; ship_y = 10'd400;
    press_shoot();
    do_move("single_spawn");
    probe_exp(207, 394, 1'b1, "single_spawn_pos");
    probe_exp(207, 393, 1'b0, "single_spawn_above");
    do_move("single_move");
    probe_exp(207, 390, 1'b1, "single_top_left");
    probe_exp(208, 395, 1'b1, "single_bot_right");
    probe_exp(209, 390, 1'b0, "single_right_edge");
    probe_exp(207, 396, 1'b0, "single_bottom_edge");
  endtask

  task automatic test_cooldown();
    do_reset();
    ship_x = 10'd200; ship_y = 10'd400;
    for (int k = 0; k < 10; k++) begin
      press_shoot();
      do_move("cooldown_move");
    end
    checks++;
    if (active_count !== 3'd2) begin
      failures++;
      $display("FAIL cooldown_total got=%0d exp=2", active_count);
    end
  endtask

  task automatic test_hit();
    do_reset();
    ship_x = 10'd300; ship_y = 10'd300;
    press_shoot();
    do_move("hit_spawn");
    probe(100, 100, 1, "hit_miss");
    probe(307, 294, 1, "hit_px0");
    probe(308, 295, 1, "hit_px1");
    probe(307, 299, 1, "hit_px2");
    do_move("hit_retire");
    checks++;
    if (hit_count !== 3'd1 || active_count !== 3'd0) begin
      failures++;
      $display("FAIL hit_result hit_count=%0d active=%0d exp=1/0", hit_count, active_count);
    end
    do_move("hit_next_frame");
  endtask

  task automatic test_offscreen();
    do_reset();
    ship_x = 10'd40; ship_y = 10'd9;
    press_shoot();
    do_move("off3_spawn");
    do_move("off3_retire");
    do_reset();
    ship_y = 10'd10;
    press_shoot();
    do_move("off4_spawn");
    do_move("off4_to_zero");
    probe_exp(47, 0, 1'b1, "off4_at_zero");
    do_move("off4_retire");
    probe_exp(47, 0, 1'b0, "off4_gone");
  endtask

  task automatic test_full_pool();
    int extra;
    do_reset();
    ship_x = 10'd100; ship_y = 10'd400;
    extra = 0;
    for (int k = 0; k < 60 && extra < 12; k++) begin
      press_shoot();
      do_move("full_fill");
      if (model_count() == NB) extra++;
    end
    checks++;
    if (active_count !== 3'd4) begin
      failures++;
      $display("FAIL full_pool_count got=%0d exp=4", active_count);
    end
  endtask

  task automatic test_same_clk_edge();
    do_reset();
    ship_x = 10'd50; ship_y = 10'd200;
    shoot = 1'b1;
    repeat (2) @(negedge clk);
    do_move("edge_at_move");
    m_pend = 1;
    shoot = 1'b0;
    repeat (3) @(negedge clk);
    do_move("edge_served");
    checks++;
    if (active_count !== 3'd1) begin
      failures++;
      $display("FAIL edge_served_count got=%0d exp=1", active_count);
    end
  endtask

  task automatic test_random();
    int s, hc, vc;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      ship_x = 10'($urandom_range(0, 1023));
      ship_y = 10'($urandom_range(0, 479));
      if ($urandom_range(0, 1) == 1) press_shoot();
      for (int p = 0; p < 10; p++) begin
        s = $urandom_range(0, NB - 1);
        if (m_act[s] != 0 && $urandom_range(0, 3) != 0) begin
          hc = (m_x[s] + $urandom_range(0, 3) - 1) & 1023;
          vc = (m_y[s] + $urandom_range(0, 7) - 1) & 1023;
        end else begin
          hc = $urandom_range(0, 1023);
          vc = $urandom_range(0, 479);
        end
        probe(hc, vc, ($urandom_range(0, 7) == 0) ? 1 : 0, "rand_probe");
      end
      do_move("rand_move");
    end
  endtask

  initial begin
    rst = 1'b0; pixpulse = 1'b0; move = 1'b0; shoot = 1'b0; hit_target = 1'b0;
    hcount = 10'd0; vcount = 10'd0; ship_x = 10'd0; ship_y = 10'd0;
    model_clear();
    test_reset();
    test_single_shot();
    test_cooldown();
    test_hit();
    test_offscreen();
    test_full_pool();
    test_same_clk_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
